// File: rtl/kyber_hash_pkg.sv
// Shared definitions for the Kyber hash front end: sequencer states and SHAKE128 constants.
package kyber_hash_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_HASH = 2'd2,
    ST_DONE = 2'd3
  } hash_state_t;

  // One 32-byte seed block per job.
  localparam int unsigned LOAD_CYCLES_DEF = 32;
  localparam int unsigned SHAKE128_RATE   = 168;

endpackage

// File: rtl/shake_arbiter_rr_pick.sv
// Combinational round-robin selector: first set req bit after 'last', wrapping to 0.
module rr_pick #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] last,
  output logic [NREQ-1:0]  pick,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // Pass one covers indices above 'last'; pass two wraps around from 0.
  always_comb begin
    pick = '0;
    idx  = '0;
    any  = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!any && (IDX_W'(i) > last) && req[i]) begin
        any     = 1'b1;
        pick[i] = 1'b1;
        idx     = IDX_W'(i);
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!any && req[i]) begin
        any     = 1'b1;
        pick[i] = 1'b1;
        idx     = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/shake_arbiter.sv
// Round-robin sharing of the SHAKE128 engine: grant, input-RAM load, start/done handshake,
// and a per-requester completion pulse.
module shake_arbiter
  import kyber_hash_pkg::*;
#(
  parameter int unsigned NREQ        = 4,
  parameter int unsigned IDX_W       = 2,
  parameter int unsigned LOAD_CYCLES = LOAD_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             set,
  input  logic [NREQ-1:0]  req,
  output logic [NREQ-1:0]  gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             busy,
  output logic             load_en,
  output logic [7:0]       load_addr,
  output logic             shake128_full_in,
  input  logic             shake128_done,
  output logic [NREQ-1:0]  req_done
);

  localparam logic [7:0] LAST_ADDR = 8'(LOAD_CYCLES - 1);

  hash_state_t      state;
  logic [IDX_W-1:0] last;
  logic [NREQ-1:0]  pick;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;

  rr_pick #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req  (req),
    .last (last),
    .pick (pick),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  // Sequencer; 'set' low freezes everything, reset overrides it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= ST_IDLE;
      gnt              <= '0;
      gnt_idx          <= '0;
      busy             <= 1'b0;
      load_en          <= 1'b0;
      load_addr        <= '0;
      shake128_full_in <= 1'b0;
      req_done         <= '0;
      last             <= IDX_W'(NREQ - 1);
    end else if (set) begin
      case (state)
        ST_IDLE: begin
          if (pick_any) begin
            gnt       <= pick;
            gnt_idx   <= pick_idx;
            busy      <= 1'b1;
            load_en   <= 1'b1;
            load_addr <= '0;
            state     <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (load_addr == LAST_ADDR) begin
            load_en          <= 1'b0;
            load_addr        <= '0;
            shake128_full_in <= 1'b1;
            state            <= ST_HASH;
          end else begin
            load_addr <= load_addr + 8'd1;
          end
        end
        ST_HASH: begin
          // gnt is the one-hot form of gnt_idx, so it doubles as the done mask.
          if (shake128_done) begin
            shake128_full_in <= 1'b0;
            req_done         <= gnt;
            last             <= gnt_idx;
            state            <= ST_DONE;
          end
        end
        ST_DONE: begin
          req_done <= '0;
          gnt      <= '0;
          busy     <= 1'b0;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shake_arbiter.sv
// Self-checking bench for shake_arbiter: scenario tasks plus a req_done scoreboard.
module tb_shake_arbiter;

  localparam int unsigned NREQ        = 4;
  localparam int unsigned IDX_W       = 2;
  localparam int unsigned LOAD_CYCLES = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic             set;
  logic [NREQ-1:0]  req;
  logic [NREQ-1:0]  gnt;
  logic [IDX_W-1:0] gnt_idx;
  logic             busy;
  logic             load_en;
  logic [7:0]       load_addr;
  logic             full_in;
  logic             done;
  logic [NREQ-1:0]  req_done;

  logic            engine_auto;
  logic            man_done;
  logic            auto_done;
  int unsigned     done_delay;
  logic            mon_on;
  logic [NREQ-1:0] prev_rd;
  logic [NREQ-1:0] exp_rd;
  logic [NREQ-1:0] exp_q[$];
  int              checks = 0;
  int              passes = 0;

  always #5 clk = ~clk;

  assign done = engine_auto ? auto_done : man_done;

  shake_arbiter #(
    .NREQ        (NREQ),
    .IDX_W       (IDX_W),
    .LOAD_CYCLES (LOAD_CYCLES)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .set              (set),
    .req              (req),
    .gnt              (gnt),
    .gnt_idx          (gnt_idx),
    .busy             (busy),
    .load_en          (load_en),
    .load_addr        (load_addr),
    .shake128_full_in (full_in),
    .shake128_done    (done),
    .req_done         (req_done)
  );

  // Engine model: raises done once full_in has been seen for more than done_delay cycles.
  initial begin : engine
    int unsigned cnt;
    cnt       = 0;
    auto_done = 1'b0;
    forever begin
      @(negedge clk);
      if (full_in === 1'b1) cnt++;
      else cnt = 0;
      auto_done = (cnt > done_delay);
    end
  end

  // Scoreboard: every new req_done pulse must match the next expected completion.
  initial begin : monitor
    prev_rd = '0;
    forever begin
      @(negedge clk);
      if (mon_on) begin
        checks++;
        if (!$onehot0(gnt) || !$onehot0(req_done)) begin
          $display("FAIL onehot: gnt=%b req_done=%b, required one-hot or zero", gnt, req_done);
        end else passes++;
        if (req_done != '0 && prev_rd == '0) begin
          checks++;
          if (exp_q.size() == 0) begin
            $display("FAIL unexpected_req_done: got %b, required no pulse", req_done);
          end else begin
            exp_rd = exp_q.pop_front();
            if (req_done !== exp_rd)
              $display("FAIL req_done_order: got %b, required %b", req_done, exp_rd);
            else passes++;
          end
        end
        prev_rd = req_done;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic wait_busy();
    int n = 0;
    while (busy !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    if (busy !== 1'b1) begin
      checks++;
      $display("FAIL wait_busy: busy=%b, required 1 within 50 cycles", busy);
    end
  endtask

  task automatic wait_req_done();
    int n = 0;
    while (req_done === '0 && n < 200) begin @(negedge clk); n++; end
    if (req_done === '0) begin
      checks++;
      $display("FAIL wait_req_done: req_done=%b, required a pulse within 200 cycles", req_done);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; set = 1'b1; req = '0;
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    checks++;
    if ({gnt, gnt_idx, busy, load_en, load_addr, full_in, req_done} !== '0)
      $display("FAIL reset_values: gnt=%b idx=%0d busy=%b load_en=%b addr=%0d full_in=%b req_done=%b, required all 0",
               gnt, gnt_idx, busy, load_en, load_addr, full_in, req_done);
    else passes++;
    mon_on = 1'b1;
  endtask

  task automatic test_single();
    int n = 0;
    int m = 0;
    logic addr_ok = 1'b1;
    req = 4'b0001;
    exp_q.push_back(4'b0001);
    @(negedge clk);
    checks++;
    if ({gnt, gnt_idx, busy, load_en, load_addr} !== {4'b0001, 2'd0, 1'b1, 1'b1, 8'd0})
      $display("FAIL single_grant: gnt=%b idx=%0d busy=%b load_en=%b addr=%0d, required 0001 0 1 1 0",
               gnt, gnt_idx, busy, load_en, load_addr);
    else passes++;
    while (load_en === 1'b1 && n < 100) begin
      if (load_addr !== 8'(n)) addr_ok = 1'b0;
      n++;
      @(negedge clk);
    end
    checks++;
    if (n != 32 || !addr_ok)
      $display("FAIL single_load: load cycles=%0d addr_seq_ok=%b, required 32 and 1", n, addr_ok);
    else passes++;
    checks++;
    if (full_in !== 1'b1) $display("FAIL single_full_in_rise: full_in=%b, required 1", full_in);
    else passes++;
    while (full_in === 1'b1 && m < 50) begin m++; @(negedge clk); end
    checks++;
    if (m != 4) $display("FAIL single_full_in_len: got %0d cycles, required 4", m);
    else passes++;
    checks++;
    if (req_done !== 4'b0001 || busy !== 1'b1)
      $display("FAIL single_req_done: req_done=%b busy=%b, required 0001 1", req_done, busy);
    else passes++;
    req = '0;
    @(negedge clk);
    checks++;
    if ({req_done, busy, gnt} !== '0)
      $display("FAIL single_release: req_done=%b busy=%b gnt=%b, required 0 0 0", req_done, busy, gnt);
    else passes++;
  endtask

  task automatic test_round_robin();
    logic [NREQ-1:0] expg;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    req = 4'b1111;
    for (int j = 0; j < 5; j++) exp_q.push_back(4'(4'b0001 << (j % 4)));
    for (int j = 0; j < 5; j++) begin
      expg = 4'(4'b0001 << (j % 4));
      wait_busy();
      checks++;
      if (gnt !== expg) $display("FAIL rr_grant%0d: gnt=%b, required %b", j, gnt, expg);
      else passes++;
      wait_req_done();
      if (j == 4) req = '0;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || gnt !== '0)
        $display("FAIL rr_idle%0d: busy=%b gnt=%b, required 0 0", j, busy, gnt);
      else passes++;
      if (j < 4) begin
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) $display("FAIL rr_regrant%0d: busy=%b, required 1", j, busy);
        else passes++;
      end
    end
  endtask

  task automatic test_stall();
    int n = 0;
    logic stalled = 1'b0;
    logic addr_ok = 1'b1;
    logic hold_ok = 1'b1;
    req = 4'b0010;
    exp_q.push_back(4'b0010);
    wait_busy();
    while (load_en === 1'b1 && n < 100) begin
      if (load_addr !== 8'(n)) addr_ok = 1'b0;
      if (load_addr == 8'd10 && !stalled) begin
        set = 1'b0;
        stalled = 1'b1;
        repeat (5) begin
          @(negedge clk);
          if ({gnt, busy, load_en, load_addr, full_in, req_done} !==
              {4'b0010, 1'b1, 1'b1, 8'd10, 1'b0, 4'b0000}) hold_ok = 1'b0;
        end
        set = 1'b1;
      end
      n++;
      @(negedge clk);
    end
    checks++;
    if (!stalled || !hold_ok)
      $display("FAIL stall_hold: stalled=%b hold_ok=%b, required 1 1", stalled, hold_ok);
    else passes++;
    checks++;
    if (n != 32 || !addr_ok)
      $display("FAIL stall_load: load set-cycles=%0d addr_seq_ok=%b, required 32 and 1", n, addr_ok);
    else passes++;
    wait_req_done();
    req = '0;
    @(negedge clk);
  endtask

  task automatic test_early_done();
    int n = 0;
    engine_auto = 1'b0;
    man_done = 1'b0;
    req = 4'b0100;
    exp_q.push_back(4'b0100);
    wait_busy();
    while (load_en === 1'b1 && n < 100) begin
      if (load_addr == 8'd5) man_done = 1'b1;
      if (load_addr == 8'd7) man_done = 1'b0;
      n++;
      @(negedge clk);
    end
    checks++;
    if (n != 32 || full_in !== 1'b1)
      $display("FAIL spurious_done_load: cycles=%0d full_in=%b, required 32 1", n, full_in);
    else passes++;
    @(negedge clk); @(negedge clk);
    checks++;
    if (full_in !== 1'b1 || req_done !== '0)
      $display("FAIL hash_wait: full_in=%b req_done=%b, required 1 0000", full_in, req_done);
    else passes++;
    man_done = 1'b1;
    @(negedge clk);
    checks++;
    if (req_done !== 4'b0100 || full_in !== 1'b0)
      $display("FAIL manual_done: req_done=%b full_in=%b, required 0100 0", req_done, full_in);
    else passes++;
    man_done = 1'b0;
    req = '0;
    @(negedge clk);
    // Done raised during LOAD and held through HASH entry.
    req = 4'b1000;
    exp_q.push_back(4'b1000);
    wait_busy();
    n = 0;
    while (load_en === 1'b1 && n < 100) begin
      if (load_addr == 8'd20) man_done = 1'b1;
      n++;
      @(negedge clk);
    end
    checks++;
    if (full_in !== 1'b1 || req_done !== '0)
      $display("FAIL early_done_hash_entry: full_in=%b req_done=%b, required 1 0000", full_in, req_done);
    else passes++;
    @(negedge clk);
    checks++;
    if (req_done !== 4'b1000 || full_in !== 1'b0)
      $display("FAIL early_done_finish: req_done=%b full_in=%b, required 1000 0", req_done, full_in);
    else passes++;
    man_done = 1'b0;
    req = '0;
    engine_auto = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_drop();
    int n = 0;
    req = 4'b0010;
    exp_q.push_back(4'b0010);
    wait_busy();
    while (full_in !== 1'b1 && n < 100) begin n++; @(negedge clk); end
    req = '0;
    wait_req_done();
    checks++;
    if (req_done !== 4'b0010) $display("FAIL drop_req_done: req_done=%b, required 0010", req_done);
    else passes++;
    @(negedge clk); @(negedge clk);
    checks++;
    if (busy !== 1'b0) $display("FAIL drop_no_regrant: busy=%b, required 0", busy);
    else passes++;
  endtask

  task automatic test_reset_mid();
    int n = 0;
    req = 4'b0100;
    wait_busy();
    checks++;
    if (gnt !== 4'b0100) $display("FAIL mid_grant: gnt=%b, required 0100", gnt);
    else passes++;
    while (load_addr !== 8'd15 && n < 100) begin n++; @(negedge clk); end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({gnt, gnt_idx, busy, load_en, load_addr, full_in, req_done} !== '0)
      $display("FAIL mid_reset_values: gnt=%b idx=%0d busy=%b load_en=%b addr=%0d full_in=%b req_done=%b, required all 0",
               gnt, gnt_idx, busy, load_en, load_addr, full_in, req_done);
    else passes++;
    reset = 1'b0;
    req = 4'b0101;
    exp_q.push_back(4'b0001);
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0001 || gnt_idx !== 2'd0)
      $display("FAIL pointer_reset: gnt=%b idx=%0d, required 0001 0", gnt, gnt_idx);
    else passes++;
    wait_req_done();
    req = '0;
    @(negedge clk); @(negedge clk);
  endtask

  initial begin
    engine_auto = 1'b1;
    man_done    = 1'b0;
    done_delay  = 3;
    mon_on      = 1'b0;
    reset       = 1'b1;
    set         = 1'b1;
    req         = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_stall();
    test_early_done();
    test_drop();
    test_reset_mid();
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) $display("FAIL missing_req_done: %0d expected pulses never seen", exp_q.size());
    else passes++;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/shake_arbiter.md
Name: shake_arbiter

Overview:
- Round-robin arbiter and sequencer that shares the single SHAKE128 hash engine (and its input RAM load path) among NREQ requesters, e.g. matrix-A row generators and the CBD sampler.
- Grants one requester at a time and drives the input-load counter.
- Runs the engine start/done handshake and returns a per-requester completion pulse.
- Sits between the requester FSMs and the hash engine / input-RAM mux.

Parameters:
- NREQ, 4, number of requesters.
- IDX_W, 2, width of grant index; must satisfy 2**IDX_W >= NREQ.
- LOAD_CYCLES, 32, number of input words transferred into the engine RAM per job (1..256).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- set  in  1  global step enable; when low, all state, counters and outputs hold.
- req  in  NREQ  per-requester job request (level); held until the matching req_done pulse.
- gnt  out  NREQ  one-hot grant, registered; steers the RAM/input mux.
- gnt_idx  out  IDX_W  binary index of the granted requester; valid while busy.
- busy  out  1  high from grant until the end of the DONE state.
- load_en  out  1  RAM write-enable into the engine input buffer.
- load_addr  out  8  input buffer address, 0..LOAD_CYCLES-1.
- shake128_full_in  out  1  engine start; level, held until shake128_done is sampled.
- shake128_done  in  1  engine completion from the hash engine.
- req_done  out  NREQ  one-cycle completion pulse for the granted requester.

Behaviour:
- Single clock; reset synchronous active-high; all updates only on edges where set=1, except reset (reset wins over set).
- Reset values:
  - state=IDLE; gnt=0; gnt_idx=0; busy=0; load_en=0; load_addr=0; shake128_full_in=0; req_done=0.
  - Round-robin pointer last=NREQ-1, so requester 0 has first priority.
- FSM states: IDLE, LOAD, HASH, DONE.
- IDLE:
  - If any req bit is high, pick the first set bit searching last+1, last+2, ... modulo NREQ.
  - Register gnt/gnt_idx; busy=1; load_en=1; load_addr=0; go to LOAD.
  - If no req bit is high, stay in IDLE.
- LOAD:
  - load_en=1 for exactly LOAD_CYCLES cycles; load_addr increments by 1 each cycle.
  - On the edge where load_addr==LOAD_CYCLES-1: load_en=0, load_addr=0, shake128_full_in=1, go to HASH.
- HASH:
  - Hold shake128_full_in=1 until shake128_done is sampled high.
  - On that edge: shake128_full_in=0; req_done[gnt_idx]=1; last=gnt_idx; go to DONE.
- DONE (one cycle):
  - On exit: req_done=0; gnt=0; busy=0; go to IDLE.
  - Minimum one IDLE cycle between jobs.
- Latency: req sampled at edge E gives gnt at E. shake128_full_in rises at E+LOAD_CYCLES. req_done pulses the cycle after done is sampled.
- Boundary conditions:
  - shake128_done high while in IDLE/LOAD/DONE: ignored.
  - shake128_done already high in the first HASH cycle: accepted on the next edge.
  - Granted req dropping mid-job: the job still completes, and req_done still pulses.
  - New req bits during a job: not considered until IDLE.
  - Several simultaneous reqs: round-robin from last+1; no requester is starved.
  - req bits above NREQ-1 do not exist.
  - set low mid-job: everything frozen, including load_addr and the req_done pulse width (stretched in real cycles, one set-cycle long).
  - reset mid-job: immediate return to reset values next edge; the in-flight job is abandoned with no req_done.
- Invariants: gnt always one-hot or zero; at most one req_done bit high at a time.

Decomposition:
- Shared package kyber_hash_pkg:
  - state encodings IDLE/LOAD/HASH/DONE;
  - default LOAD_CYCLES=32 (one 32-byte seed block);
  - SHAKE128 rate constant 168 for later reuse.
- One sub-module rr_pick: combinational round-robin priority selector. Inputs: req, last. Outputs: one-hot pick, binary idx, any.
- The rest (FSM, load counter) stays in shake_arbiter.

Test Plan:
- Single requester, NREQ=4, LOAD_CYCLES=32. reset, then req=0001 held; engine asserts done 3 cycles after full_in rises. Required:
  - gnt=0001 one cycle after req is sampled;
  - load_en high 32 cycles, addr 0..31;
  - full_in high 4 cycles;
  - req_done=0001 for one cycle, then busy=0.
- Round-robin: req=1111 held continuously. Required: grant order 0,1,2,3,0; exactly one req_done per job; one IDLE cycle between jobs.
- Stall: toggle set low for 5 cycles at load_addr=10. Required: addr holds at 10; total load_en set-cycles still 32; no output changes while set=0.
- Early and spurious done:
  - done pulsed during LOAD: ignored, and full_in still rises.
  - done held high from before HASH: job finishes 1 cycle after entering HASH.
- Reset mid-job: reset at load_addr=15 with req=0100. Required:
  - next edge: all outputs 0 and state IDLE;
  - next grant is req0 if req=0101, confirming pointer reset;
  - no req_done for the abandoned job.
- Request drop: req[1] deasserted during HASH. Required: job completes and req_done=0010 still pulses once.
